// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment display controller.
// Scans NUM_DIGITS hex digits over one shared segment bus with one-hot digit select.
// Loaded values wait in a shadow register and are committed only at a frame boundary.
// Optional feature macro: SEG_BLANK_LZ_EN (leading-zero blanking).
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int unsigned DW     = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PC_W   = $clog2(SCAN_DIV);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [PC_W-1:0]       pcnt_q, pcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [DW-1:0]         dsp_data_q, dsp_data_d;
  logic [NUM_DIGITS-1:0] dsp_dp_q, dsp_dp_d;
  logic                  pend_q, pend_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  fd_q, fd_d;
  logic                  boundary_c;
  logic [3:0]            nib_c;
  logic [7:0]            raw_c;

  // Hex nibble to active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

`ifdef SEG_BLANK_LZ_EN
  logic [NUM_DIGITS-1:0] blank_c;
  logic                  seen_c;

  // Mark digits above the most significant nonzero nibble; digit 0 never blanks
  always_comb begin
    blank_c = '0;
    seen_c  = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (dsp_data_q[4*i +: 4] != 4'h0) seen_c = 1'b1;
      blank_c[i] = ~seen_c;
    end
  end
`endif

  // Scan counters, shadow/display commit and registered output decode
  always_comb begin
    pcnt_d     = pcnt_q + PC_W'(1);
    idx_d      = idx_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    dsp_data_d = dsp_data_q;
    dsp_dp_d   = dsp_dp_q;
    pend_d     = pend_q;
    boundary_c = (pcnt_q == PC_LAST) && (idx_q == IDX_LAST);

    if (pcnt_q == PC_LAST) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (load) begin
      shd_data_d = data_in;
      shd_dp_d   = dp_in;
    end

    // A load on the boundary bypasses the shadow so it never shows as pending
    if (boundary_c) begin
      pend_d = 1'b0;
      if (load) begin
        dsp_data_d = data_in;
        dsp_dp_d   = dp_in;
      end else if (pend_q) begin
        dsp_data_d = shd_data_q;
        dsp_dp_d   = shd_dp_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end

    fd_d  = (pcnt_d == PC_LAST) && (idx_d == IDX_LAST);
    nib_c = 4'(dsp_data_q >> {idx_q, 2'b00});
    raw_c = {dsp_dp_q[idx_q], hex_to_seg(nib_c)};
`ifdef SEG_BLANK_LZ_EN
    if (blank_c[idx_q]) raw_c[6:0] = 7'h00;
`endif
    seg_d = SEG_ACTIVE_LOW ? ~raw_c : raw_c;
    dig_d = NUM_DIGITS'(1) << idx_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      dsp_data_q <= '0;
      dsp_dp_q   <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      dsp_data_q <= dsp_data_d;
      dsp_dp_q   <= dsp_dp_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = fd_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (4 digits, 4-cycle scan, active-low).
// Reference rule: frame f shows the latest value loaded in any cycle before f*FRAME.
module tb_seg_scan_display;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int FRAME = ND * SD;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            load = 1'b0;
  logic [4*ND-1:0] data_in = '0;
  logic [ND-1:0]   dp_in = '0;
  logic [7:0]      seg_out;
  logic [ND-1:0]   dig_sel;
  logic            frame_done;
  logic            pending;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] frame_q[$];
  bit          pend_q[$];

  seg_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .dp_in(dp_in),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // Glyph of a hex nibble, segments a..g active-high
  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Expected active-low pattern for digit d of {dp[3:0], hex[15:0]}
  function automatic logic [7:0] exp_seg(input logic [19:0] v, input int d);
    int          value;
    logic [7:0]  s;
    value = int'(v[15:0]);
    s = {v[16+d], glyph((value / (1 << (4*d))) % 16)};
`ifdef SEG_BLANK_LZ_EN
    if (d > 0 && value < (1 << (4*d))) s[6:0] = 7'h00;
`endif
    return ~s;
  endfunction

  task automatic check_off(input string tag);
    chk({tag, "_seg"}, 32'(seg_out), 32'hFF);
    chk({tag, "_dig"}, 32'(dig_sel), 32'h0);
    chk({tag, "_fd"},  32'(frame_done), 32'h0);
    chk({tag, "_pend"}, 32'(pending), 32'h0);
  endtask

  // Stimulus: one cycle per iteration, pushes expected frame values and pending flags
  task automatic drive(input int ep, input int ncyc);
    logic [19:0] last_val;
    bit          pend;
    bit          do_load;
    logic [19:0] v;
    last_val = '0;
    pend     = 1'b0;
    frame_q.push_back(20'h0);
    for (int c = 0; c < ncyc; c++) begin
      do_load = 1'b0;
      v = '0;
      if (ep == 1 && c < 64) begin
        case (c)
          5:  begin do_load = 1'b1; v = 20'h012AF; end
          20: begin do_load = 1'b1; v = 20'h01111; end
          25: begin do_load = 1'b1; v = 20'h02222; end
          47: begin do_load = 1'b1; v = 20'h00005; end
          default: ;
        endcase
      end else if (ep != 0) begin
        do_load = ($urandom_range(0, 9) == 0) || (ep == 1 && c == ncyc - 1);
        v[19:16] = 4'($urandom);
        v[15:0]  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      end
      load    = do_load;
      data_in = v[15:0];
      dp_in   = v[19:16];
      if (do_load) begin
        last_val = v;
        pend = ((c + 1) % FRAME) != 0;
      end else begin
        pend = pend && (((c + 1) % FRAME) != 0);
      end
      pend_q.push_back(pend);
      if (((c + 1) % FRAME) == 0) frame_q.push_back(last_val);
      @(posedge clk);
      #1;
    end
    load = 1'b0;
  endtask

  // Monitor: checks every post-edge cycle against the popped expectations
  task automatic monitor(input int ncyc);
    logic [19:0] cur;
    int pos;
    int d;
    cur = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      pos = (c - 1) % FRAME;
      d   = pos / SD;
      if (pos == 0) begin
        n_vec++;
        if (frame_q.size() == 0) begin
          n_err++;
          $display("FAIL frame_queue @%0t: got empty, required an expected frame", $time);
        end else begin
          cur = frame_q.pop_front();
        end
      end
      chk("seg_out", 32'(seg_out), 32'(exp_seg(cur, d)));
      chk("dig_sel", 32'(dig_sel), 32'(1 << d));
      chk("frame_done", 32'(frame_done), 32'((c % FRAME) == FRAME - 1));
      n_vec++;
      if (pend_q.size() == 0) begin
        n_err++;
        $display("FAIL pend_queue @%0t: got empty, required an expected flag", $time);
      end else begin
        chk("pending", 32'(pending), 32'(pend_q.pop_front()));
      end
    end
  endtask

  initial begin
    int ncyc;
    // Power-on reset held
    repeat (3) @(negedge clk);
    check_off("reset_hold");
    for (int ep = 0; ep < 3; ep++) begin
      ncyc = (ep == 0) ? 64 : (ep == 1) ? 100 : 400;
      frame_q.delete();
      pend_q.delete();
      @(negedge clk);
      reset = 1'b1;
      fork
        drive(ep, ncyc);
        monitor(ncyc);
      join
      // Asynchronous reset mid-cycle; after episode 1 a value is still pending
      #2 reset = 1'b0;
      #1 check_off("async_reset");
      repeat (2) @(negedge clk);
      check_off("reset_held");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, time-multiplexed seven-segment display controller for the MiniSRC board; successor to the fixed two-digit upper/lower segment outputs of the datapath. Drives NUM_DIGITS hex digits from one shared segment bus with a one-hot digit select. A load strobe captures a new value, which is committed only at a frame boundary so a scan frame never shows mixed old and new digits. Typically fed from Outport_Data_Out.

## Interface
- NUM_DIGITS, 8, digits scanned; range 1–8.
- SCAN_DIV, 50000, clk cycles each digit is held; must be ≥2.
- SEG_ACTIVE_LOW, 1, 1: segment outputs are active-low; 0: active-high.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  capture data_in/dp_in into the shadow register this cycle.
- data_in  in  4*NUM_DIGITS  hex value; nibble i maps to digit i, digit 0 = least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit, active-high.
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, registered.
- dig_sel  out  NUM_DIGITS  one-hot active-high digit enable, registered.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- pending  out  1  shadow holds an uncommitted value.

## Operation
- State: prescaler pcnt (0..SCAN_DIV-1), digit index idx (0..NUM_DIGITS-1), shadow reg, display reg, pending flag.
- Each cycle pcnt increments; at SCAN_DIV-1 it wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
- Boundary cycle: pcnt==SCAN_DIV-1 and idx==NUM_DIGITS-1; frame_done=1 that cycle only.
- load: shadow <= {dp_in,data_in}, pending <= 1. Repeated loads before a boundary: last one wins.
- Boundary with pending=1: display <= shadow, pending <= 0.
- load on the boundary cycle: data goes directly into display and shadow, pending stays 0.
- Decode of display nibble idx (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; bit 7 = dp bit idx. SEG_ACTIVE_LOW=1 inverts all 8 bits.
- dig_sel = 1<<idx.
- Reset (asserted, asynchronous): pcnt=0, idx=0, shadow=0, display=0, pending=0, frame_done=0, dig_sel=0, seg_out = all off (8'hFF active-low / 8'h00 active-high).
- Reset asserted mid-frame or with pending=1: pending value discarded; the block restarts at digit 0 after release.

## Timing
- seg_out/dig_sel are registered: they reflect idx/display one cycle after they change. First clk edge after reset release drives digit 0 from display=0.
- Each digit is shown exactly SCAN_DIV cycles; frame = NUM_DIGITS*SCAN_DIV cycles.
- load-to-display latency: from 1 cycle (load on boundary) up to NUM_DIGITS*SCAN_DIV cycles.
- pending rises the cycle after load and falls the cycle after commit.
- No tearing: display changes only at the boundary edge, so all digits of one frame come from one value.

## Configuration
- SEG_BLANK_LZ_EN defined: leading-zero blanking. Digits above the most significant nonzero nibble show all segments off, including dp unless that digit's dp_in=1. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all NUM_DIGITS digits are always shown, including leading zeros.

## Test plan
- NUM_DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=1. Reset held, then released with no load -> seg_out=8'hFF and dig_sel=0 during reset; after release, each digit shows 8'hC0 ("0") for 4 cycles; dig_sel cycles 1,2,4,8; frame_done every 16 cycles.
- Mid-frame load data_in=16'h12AF -> pending=1; display unchanged until the boundary. Next frame: digit0=8'h8E (F), digit1=8'h88 (A), digit2=8'hA4 (2), digit3=8'hF9 (1); pending=0.
- Two loads in one frame, 16'h1111 then 16'h2222 -> only 2222 is ever displayed.
- Load 16'h0005 exactly on the frame_done cycle -> next frame shows 0005; pending never rises.
- SEG_BLANK_LZ_EN defined, load 16'h0005 -> digits 3..1 = 8'hFF, digit0 = 8'h92. Load 0 -> digit0 = 8'hC0, others blank. Without the macro, 0005 shows C0,C0,C0,92.
- Reset asserted mid-frame with pending=1 -> outputs go off immediately (asynchronously); after release, display=0 and the pending value is not shown.
